// File: rtl/mem_spi_flash_responder_if.sv
// SPI/QSPI flash link pins as seen between a controller (master) and the flash target (slave).
interface mem_spi_flash_responder_if;
    logic       in_sclk;
    logic       in_cs_n;
    logic [3:0] in_io;
    logic [3:0] out_io;
    logic [3:0] io_ena;

    modport master (
        output in_sclk,
        output in_cs_n,
        output in_io,
        input  out_io,
        input  io_ena
    );

    modport slave (
        input  in_sclk,
        input  in_cs_n,
        input  in_io,
        output out_io,
        output io_ena
    );
endinterface

// File: rtl/mem_spi_flash_responder.sv
// SPI/QSPI flash target model: oversampled link, small byte array, backdoor port.
// Define FLASH_RSP_QUAD_PROGRAM_EN to accept opcode 0x32 (quad page program).
module mem_spi_flash_responder #(
    parameter int unsigned MEM_AW      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned QREAD_DUMMY = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mem_spi_flash_responder_if.slave spi_io,
    output logic                     out_busy,
    output logic                     out_cmd_err,
    input  logic                     bd_we,
    input  logic [MEM_AW-1:0]        bd_addr,
    input  logic [7:0]               bd_wdata,
    output logic [7:0]               bd_rdata
);

`ifdef FLASH_RSP_QUAD_PROGRAM_EN
    localparam bit QuadProgEn = 1'b1;
`else
    localparam bit QuadProgEn = 1'b0;
`endif

    localparam int unsigned Depth = 1 << MEM_AW;
    localparam int unsigned PgW   = (MEM_AW < 8) ? MEM_AW : 8;
    localparam logic [MEM_AW-1:0] PgMask = MEM_AW'((1 << PgW) - 1);

    localparam logic [7:0] OpRead  = 8'h03;
    localparam logic [7:0] OpQRead = 8'h6B;
    localparam logic [7:0] OpPp    = 8'h02;
    localparam logic [7:0] OpWren  = 8'h06;
    localparam logic [7:0] OpWrdi  = 8'h04;
    localparam logic [7:0] OpRdsr  = 8'h05;
    localparam logic [7:0] OpQpp   = 8'h32;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StRdData, StWrData, StStatus, StIgnore
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0]   sclk_sync_q, cs_sync_q;
    logic [4*SYNC_STAGES-1:0] io_sync_q;
    logic                     sclk_prev_q, cs_prev_q;
    logic                     sclk_s, cs_s, sclk_rise, sclk_fall, cs_rise;
    logic [3:0]               io_s;

    logic [7:0]        cnt_q, cnt_d;
    logic [6:0]        sh_q, sh_d;
    logic [7:0]        op_q, op_d;
    logic [MEM_AW-1:0] addr_q, addr_d, addr_pg_inc;
    logic              quad_q, quad_d;
    logic              wel_q, wel_d;
    logic              wrote_q, wrote_d;
    logic [3:0]        out_io_q, out_io_d;
    logic              cmd_err_q, cmd_err_d;
    logic              busy_q;

    logic [7:0] mem [Depth];
    logic [7:0] rd_byte, st_byte, cmd_byte, wr_byte, mem_wdata;
    logic       mem_we, cmd_last, addr_last, dummy_last, unit_last, qpp_ok;

    // Data is synchronized through the same depth as sclk so it stays aligned with the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            io_sync_q   <= '0;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_io.in_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_io.in_cs_n};
            io_sync_q   <= {io_sync_q[4*SYNC_STAGES-5:0], spi_io.in_io};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign io_s      = io_sync_q[4*SYNC_STAGES-1 -: 4];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    assign rd_byte     = mem[addr_q];
    assign st_byte     = {6'b0, wel_q, 1'b0};
    assign cmd_byte    = {sh_q, io_s[0]};
    assign wr_byte     = quad_q ? {sh_q[3:0], io_s} : {sh_q, io_s[0]};
    assign mem_wdata   = rd_byte & wr_byte;
    assign cmd_last    = (cnt_q == 8'd7);
    assign addr_last   = (cnt_q == 8'd23);
    assign dummy_last  = (cnt_q == 8'(QREAD_DUMMY - 1));
    assign unit_last   = quad_q ? (cnt_q == 8'd1) : (cnt_q == 8'd7);
    assign qpp_ok      = QuadProgEn && (cmd_byte == OpQpp);
    assign addr_pg_inc = (addr_q & ~PgMask) | ((addr_q + MEM_AW'(1)) & PgMask);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: if (!cs_s) state_d = StCmd;
                StCmd: begin
                    if (sclk_rise && cmd_last) begin
                        case (cmd_byte)
                            OpRead, OpQRead, OpPp: state_d = StAddr;
                            OpRdsr:                state_d = StStatus;
                            default:               state_d = qpp_ok ? StAddr : StIgnore;
                        endcase
                    end
                end
                StAddr: begin
                    if (sclk_rise && addr_last) begin
                        case (op_q)
                            OpRead:  state_d = StRdData;
                            OpQRead: state_d = StDummy;
                            default: state_d = wel_q ? StWrData : StIgnore;
                        endcase
                    end
                end
                StDummy: if (sclk_rise && dummy_last) state_d = StRdData;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath next-state
    always_comb begin
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        op_d      = op_q;
        addr_d    = addr_q;
        quad_d    = quad_q;
        wel_d     = wel_q;
        wrote_d   = wrote_q;
        out_io_d  = out_io_q;
        cmd_err_d = 1'b0;
        mem_we    = 1'b0;
        if (cs_rise) begin
            // wrote_q can only be set by a program that started with WEL=1
            cnt_d    = '0;
            out_io_d = '0;
            wrote_d  = 1'b0;
            if (wrote_q) wel_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    wrote_d = 1'b0;
                    quad_d  = 1'b0;
                    if (!cs_s && sclk_rise) begin
                        sh_d  = {sh_q[5:0], io_s[0]};
                        cnt_d = 8'd1;
                    end
                end
                StCmd: begin
                    if (sclk_rise) begin
                        sh_d  = {sh_q[5:0], io_s[0]};
                        cnt_d = cnt_q + 8'd1;
                        if (cmd_last) begin
                            cnt_d  = '0;
                            op_d   = cmd_byte;
                            quad_d = (cmd_byte == OpQRead) || qpp_ok;
                            case (cmd_byte)
                                OpWren:                        wel_d = 1'b1;
                                OpWrdi:                        wel_d = 1'b0;
                                OpRead, OpQRead, OpPp, OpRdsr: cmd_err_d = 1'b0;
                                default:                       cmd_err_d = !qpp_ok;
                            endcase
                        end
                    end
                end
                StAddr: begin
                    if (sclk_rise) begin
                        addr_d = {addr_q[MEM_AW-2:0], io_s[0]};
                        cnt_d  = addr_last ? 8'd0 : cnt_q + 8'd1;
                    end
                end
                StDummy: begin
                    if (sclk_rise) cnt_d = dummy_last ? 8'd0 : cnt_q + 8'd1;
                end
                StRdData: begin
                    if (sclk_fall) begin
                        if (quad_q) out_io_d = cnt_q[0] ? rd_byte[3:0] : rd_byte[7:4];
                        else        out_io_d = {2'b00, rd_byte[~cnt_q[2:0]], 1'b0};
                        cnt_d = unit_last ? 8'd0 : cnt_q + 8'd1;
                        if (unit_last) addr_d = addr_q + MEM_AW'(1);
                    end
                end
                StStatus: begin
                    if (sclk_fall) begin
                        out_io_d = {2'b00, st_byte[~cnt_q[2:0]], 1'b0};
                        cnt_d    = cmd_last ? 8'd0 : cnt_q + 8'd1;
                    end
                end
                StWrData: begin
                    if (sclk_rise) begin
                        sh_d  = wr_byte[6:0];
                        cnt_d = cnt_q + 8'd1;
                        if (unit_last) begin
                            cnt_d   = '0;
                            mem_we  = 1'b1;
                            addr_d  = addr_pg_inc;
                            wrote_d = 1'b1;
                        end
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            sh_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            quad_q    <= 1'b0;
            wel_q     <= 1'b0;
            wrote_q   <= 1'b0;
            out_io_q  <= '0;
            cmd_err_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            quad_q    <= quad_d;
            wel_q     <= wel_d;
            wrote_q   <= wrote_d;
            out_io_q  <= out_io_d;
            cmd_err_q <= cmd_err_d;
            busy_q    <= ~cs_s;
        end
    end

    // Array is never reset; the SPI write is issued last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (bd_we)  mem[bd_addr] <= bd_wdata;
        if (mem_we) mem[addr_q]  <= mem_wdata;
    end

    // Output logic
    always_comb begin
        spi_io.io_ena = 4'b0000;
        if (!cs_s) begin
            case (state_q)
                StRdData: spi_io.io_ena = quad_q ? 4'b1111 : 4'b0010;
                StStatus: spi_io.io_ena = 4'b0010;
                default:  spi_io.io_ena = 4'b0000;
            endcase
        end
    end

    assign spi_io.out_io = out_io_q;
    assign out_busy      = busy_q;
    assign out_cmd_err   = cmd_err_q;
    assign bd_rdata      = mem[bd_addr];

endmodule
